// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared constants for the MMIO PWM audio block: default parameters, register
// byte offsets, CTRL/STATUS bit positions and the register address decoder.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package audio_pkg;

  // Default parameter values
  localparam int          DEF_NUM_CH     = 2;
  localparam int          DEF_PWM_BITS   = 8;
  localparam int          DEF_FIFO_DEPTH = 16;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_0400;

  // Register byte offsets from BASE_ADDR
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_DIV    = 32'h04;
  localparam logic [31:0] OFF_DATA   = 32'h08;
  localparam logic [31:0] OFF_STATUS = 32'h0C;
  localparam logic [31:0] OFF_THRESH = 32'h10;

  // CTRL bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  // STATUS bit positions (count occupies [7:0])
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_UNF_BIT   = 10;
  localparam int ST_OVF_BIT   = 11;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_DIV,
    REG_DATA,
    REG_STATUS,
    REG_THRESH,
    REG_NONE
  } reg_sel_e;

  // Full 32-bit compare: anything that is not exactly one of the five
  // register addresses decodes to REG_NONE.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    case (off)
      OFF_CTRL:   return REG_CTRL;
      OFF_DIV:    return REG_DIV;
      OFF_DATA:   return REG_DATA;
      OFF_STATUS: return REG_STATUS;
      OFF_THRESH: return REG_THRESH;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, DEPTH a power of two.
//   clk, rst_n      : clock, synchronous active-low reset
//   push_i, data_i  : write request and data (ignored while full)
//   pop_i           : read request (ignored while empty)
//   flush_i         : empties the FIFO, overriding any push/pop that cycle
//   data_o          : head entry (valid while !empty_o)
//   full_o, empty_o, count_o : occupancy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/audio_mmio_pwm.sv
// -----------------------------------------------------------------------------
// audio_mmio_pwm
// Memory-mapped PWM audio output. Sample frames (one duty value per channel)
// are written to a FIFO; a programmable sample tick moves the head frame into
// shadow registers, which are copied to the active duty registers only when
// the PWM counter wraps so each PWM period uses a single duty value.
//   clk, rst_n : clock, synchronous active-low reset
//   we_i, re_i : bus write / read strobes
//   addr_i     : byte address, decoded against BASE_ADDR
//   wdata_i    : write data
//   rdata_o    : registered read data
//   pwm_o      : registered PWM output per channel
//   irq_o      : registered level interrupt
// Bus handshake: we_i and re_i are single-cycle strobes that are always
// accepted (there is no ready). A write takes effect on the strobe's clock
// edge; read data appears on rdata_o on the edge after re_i and then holds
// until the next read.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module audio_mmio_pwm
  import audio_pkg::*;
#(
  parameter int          NUM_CH     = DEF_NUM_CH,
  parameter int          PWM_BITS   = DEF_PWM_BITS,
  parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq_o
);

  localparam int DW = NUM_CH * PWM_BITS;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e sel;
  logic     wr_ctrl, wr_div, wr_data, wr_status, wr_thresh;
  logic     flush, tick, pop, wrap;

  logic                en_q,      en_d;
  logic [15:0]         div_q,     div_d;
  logic [7:0]          thresh_q,  thresh_d;
  logic                unf_q,     unf_d;
  logic                ovf_q,     ovf_d;
  logic [15:0]         timer_q,   timer_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0]       shadow_q,  shadow_d;
  logic [DW-1:0]       duty_q,    duty_d;
  logic [NUM_CH-1:0]   pwm_q,     pwm_d;
  logic                irq_q,     irq_d;
  logic [31:0]         rdata_q,   rdata_d;

  logic [DW-1:0] fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    count8;
  logic [31:0]   status_w;
  logic          unused_wdata;

  // Not every write-data bit maps to a register field.
  assign unused_wdata = ^wdata_i;

  assign sel       = decode_addr(addr_i, BASE_ADDR);
  assign wr_ctrl   = we_i && (sel == REG_CTRL);
  assign wr_div    = we_i && (sel == REG_DIV);
  assign wr_data   = we_i && (sel == REG_DATA);
  assign wr_status = we_i && (sel == REG_STATUS);
  assign wr_thresh = we_i && (sel == REG_THRESH);

  assign flush = wr_ctrl && wdata_i[CTRL_FLUSH_BIT];
  assign tick  = en_q && (timer_q == div_q);
  assign pop   = tick && !fifo_empty;
  assign wrap  = en_q && (pwm_cnt_q == '1);

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_data),
    .data_i  (wdata_i[DW-1:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    count8 = '0;
    count8[CW-1:0] = fifo_count;
  end

  always_comb begin
    status_w               = '0;
    status_w[7:0]          = count8;
    status_w[ST_EMPTY_BIT] = fifo_empty;
    status_w[ST_FULL_BIT]  = fifo_full;
    status_w[ST_UNF_BIT]   = unf_q;
    status_w[ST_OVF_BIT]   = ovf_q;
  end

  always_comb begin
    en_d      = en_q;
    div_d     = div_q;
    thresh_d  = thresh_q;
    unf_d     = unf_q;
    ovf_d     = ovf_q;
    timer_d   = timer_q;
    pwm_cnt_d = pwm_cnt_q;
    shadow_d  = shadow_q;
    duty_d    = duty_q;
    pwm_d     = '0;
    irq_d     = 1'b0;
    rdata_d   = rdata_q;

    if (wr_ctrl)   en_d     = wdata_i[CTRL_EN_BIT];
    if (wr_div)    div_d    = wdata_i[15:0];
    if (wr_thresh) thresh_d = wdata_i[7:0];

    // Sticky flags: a new event in the same cycle as the clear wins.
    if (wr_status && wdata_i[ST_UNF_BIT]) unf_d = 1'b0;
    if (tick && fifo_empty)               unf_d = 1'b1;
    if (wr_status && wdata_i[ST_OVF_BIT]) ovf_d = 1'b0;
    if (wr_data && fifo_full)             ovf_d = 1'b1;

    // Tick timer: counts 0..DIV, restarts on a DIV write, parked while off.
    if (!en_q || wr_div || tick) timer_d = '0;
    else                         timer_d = timer_q + 16'd1;

    pwm_cnt_d = en_q ? (pwm_cnt_q + PWM_BITS'(1)) : '0;

    if (pop)  shadow_d = fifo_head;
    if (wrap) duty_d   = shadow_q;

    for (int c = 0; c < NUM_CH; c++) begin
      pwm_d[c] = en_q && (pwm_cnt_q < duty_q[c*PWM_BITS +: PWM_BITS]);
    end

    irq_d = (en_q && (count8 <= thresh_q)) || unf_q || ovf_q;

    if (re_i) begin
      case (sel)
        REG_CTRL:   rdata_d = {31'b0, en_q};
        REG_DIV:    rdata_d = {16'b0, div_q};
        REG_STATUS: rdata_d = status_w;
        REG_THRESH: rdata_d = {24'b0, thresh_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      div_q     <= '0;
      thresh_q  <= '0;
      unf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      pwm_cnt_q <= '0;
      shadow_q  <= '0;
      duty_q    <= '0;
      pwm_q     <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      en_q      <= en_d;
      div_q     <= div_d;
      thresh_q  <= thresh_d;
      unf_q     <= unf_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      pwm_cnt_q <= pwm_cnt_d;
      shadow_q  <= shadow_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign pwm_o   = pwm_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_audio_mmio_pwm.sv
`timescale 1ns/1ps
module tb_audio_mmio_pwm;

  localparam logic [31:0] BASE   = 32'h400;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_DIV  = 32'h04;
  localparam logic [31:0] A_DATA = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_THR  = 32'h10;
  localparam logic [31:0] A_NONE = 32'h14;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [1:0]  pwm;
  logic        irq;

  always #5 clk = ~clk;

  audio_mmio_pwm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .pwm_o   (pwm),
    .irq_o   (irq)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];      // frames the FIFO should hold, oldest first
  logic        m_unf = 1'b0;
  logic        m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int s;
    s = exp_q.size();
    return {20'h0, m_ovf, m_unf, (s == DEPTH), (s == 0), 8'(s)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = BASE + off; wdata = d;
    @(negedge clk);
    we = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
    @(negedge clk);
    re = 1'b1; addr = BASE + off;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(off, v);
    check(tag, v, exp);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] v;
    bus_read(A_STAT, v);
    check(tag, v, exp_status());
  endtask

  // Push one frame; the model applies the FIFO acceptance rule.
  task automatic push_frame(input logic [15:0] f);
    bus_write(A_DATA, {16'h0, f});
    if (exp_q.size() < DEPTH) exp_q.push_back(f);
    else                      m_ovf = 1'b1;
  endtask

  task automatic measure(input int n, output int h0, output int h1);
    h0 = 0; h1 = 0;
    repeat (n) begin
      @(posedge clk); #1;
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    logic [15:0] f;
    logic [7:0]  m_thr;
    logic [15:0] m_div;
    int          h0, h1, n, op;
    logic [15:0] frames [5];

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    check_reg("rst_ctrl", A_CTRL, 32'h0);
    check_reg("rst_div", A_DIV, 32'h0);
    check_reg("rst_thresh", A_THR, 32'h0);
    check_status("rst_status");

    // Unmapped addresses: writes ignored, reads zero
    bus_write(A_NONE, 32'hFFFF_FFFF);
    bus_write(32'h0 - BASE, 32'hFFFF_FFFF);
    check_reg("unmapped_rd", A_NONE, 32'h0);
    check_reg("unmapped_ctrl", A_CTRL, 32'h0);
    check_status("unmapped_status");

    // Randomized register traffic with EN=0 (no ticks)
    m_thr = '0; m_div = '0;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        push_frame(16'($urandom));
      end else if (op == 5) begin
        bus_write(A_CTRL, 32'h2);
        exp_q.delete();
      end else if (op == 6) begin
        v = 32'($urandom_range(0, 3)) << 10;
        bus_write(A_STAT, v);
        if (v[10]) m_unf = 1'b0;
        if (v[11]) m_ovf = 1'b0;
      end else if (op == 7) begin
        v = $urandom;
        bus_write(A_THR, v);
        m_thr = v[7:0];
        check_reg("rand_thresh", A_THR, {24'h0, m_thr});
      end else if (op == 8) begin
        v = $urandom;
        bus_write(A_DIV, v);
        m_div = v[15:0];
        check_reg("rand_div", A_DIV, {16'h0, m_div});
      end else begin
        check_reg("rand_unmapped", A_NONE, 32'h0);
      end
      check_status("rand_status");
      check("rand_irq", 32'(irq), 32'(m_unf | m_ovf));
    end

    // Overflow: 17 pushes into depth 16
    bus_write(A_CTRL, 32'h2);
    exp_q.delete();
    bus_write(A_STAT, 32'hC00);
    m_unf = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < 17; i++) push_frame(16'($urandom));
    check_status("ovf_status");
    check("ovf_irq", 32'(irq), 32'h1);
    bus_write(A_STAT, 32'h800);
    m_ovf = 1'b0;
    check_status("ovf_clear");
    check("ovf_irq_clear", 32'(irq), 32'h0);

    // Flush a full FIFO
    bus_write(A_CTRL, 32'h2);
    exp_q.delete();
    check_status("flush_status");

    // Enable with empty FIFO: underrun, output stays low
    bus_write(A_DIV, 32'd3);
    bus_write(A_CTRL, 32'h1);
    repeat (30) @(posedge clk);
    measure(256, h0, h1);
    check("unf_pwm0", 32'(h0), 32'h0);
    check("unf_pwm1", 32'(h1), 32'h0);
    m_unf = 1'b1;
    check_status("unf_status");
    check("unf_irq", 32'(irq), 32'h1);

    // Duty cycles over one PWM period, duty held across later underruns
    frames[0] = 16'h4080;
    frames[1] = 16'h00FF;
    for (int i = 2; i < 5; i++) frames[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) begin
      push_frame(frames[i]);
      repeat (600) @(posedge clk);
      measure(256, h0, h1);
      f = exp_q.pop_front();
      check("duty_ch0", 32'(h0), 32'(f[7:0]));
      check("duty_ch1", 32'(h1), 32'(f[15:8]));
    end
    check_status("duty_status");

    // EN=0 forces outputs low
    bus_write(A_CTRL, 32'h0);
    repeat (3) @(posedge clk);
    measure(64, h0, h1);
    check("dis_pwm", 32'(h0 + h1), 32'h0);

    // Threshold interrupt timing
    bus_write(A_STAT, 32'hC00);
    m_unf = 1'b0; m_ovf = 1'b0;
    bus_write(A_THR, 32'd2);
    for (int i = 0; i < 4; i++) push_frame(16'($urandom));
    bus_write(A_DIV, 32'd9);
    @(posedge clk); #1;
    check("thr_irq_pre", 32'(irq), 32'h0);
    bus_write(A_CTRL, 32'h1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!irq && n < 100);
    // Ticks every 10 cycles: count hits 2 at the 20th edge, irq one later.
    check("thr_irq_rise_cycle", 32'(n), 32'd21);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    // Push landing on the same edge as the third tick
    repeat (8) @(posedge clk);
    f = 16'($urandom);
    bus_write(A_DATA, {16'h0, f});
    void'(exp_q.pop_front());
    exp_q.push_back(f);
    check_status("pushpop_status");
    check("pushpop_irq", 32'(irq), 32'h1);

    // Reset mid-stream with five frames queued
    bus_write(A_DIV, 32'hFFFF);
    for (int i = 0; i < 3; i++) push_frame(16'($urandom));
    check_status("prerst_status");
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_pwm", 32'(pwm), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
    m_unf = 1'b0; m_ovf = 1'b0;
    check_reg("midrst_ctrl", A_CTRL, 32'h0);
    check_reg("midrst_div", A_DIV, 32'h0);
    check_reg("midrst_thresh", A_THR, 32'h0);
    check_reg("midrst_data", A_DATA, 32'h0);
    check_status("midrst_status");

    // Old FIFO contents must not resurface after reset
    push_frame(16'h2010);
    bus_write(A_CTRL, 32'h1);
    repeat (600) @(posedge clk);
    measure(256, h0, h1);
    f = exp_q.pop_front();
    check("postrst_ch0", 32'(h0), 32'(f[7:0]));
    check("postrst_ch1", 32'(h1), 32'(f[15:8]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
